// File: rtl/tile_mem_arbiter.sv
// Tile RAM port arbiter: video reads take absolute priority; two round-robin writers share the other cycles.
// Optional TILE_ARB_BLANK_WR_EN restricts writes to the blanking interval.
module tile_mem_arbiter #(
  parameter int unsigned MAP_W = 20,
  parameter int unsigned MAP_H = 15
) (
  input  logic       CLOCK_50,
  input  logic       KEY,
  input  logic       pixel_tick,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic [1:0] w_req,
  input  logic [8:0] w_addr0,
  input  logic [8:0] w_addr1,
  input  logic [2:0] w_data0,
  input  logic [2:0] w_data1,
  output logic [1:0] w_gnt,
  output logic [8:0] mem_addr,
  output logic       mem_we,
  output logic [2:0] mem_wdata,
  input  logic [2:0] mem_rdata,
  output logic [2:0] tile_code,
  output logic       tile_valid,
  output logic [7:0] err_cnt
);

  localparam int unsigned AW       = 9;
  localparam int unsigned DW       = 3;
  localparam int unsigned EW       = 8;
  localparam int unsigned TILE_CNT = MAP_W * MAP_H;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_VRD,
    SLOT_WR
  } slot_t;

  slot_t           slot_c;
  logic            win_c;
  logic            wr_ok_c;
  logic            wr_window_c;
  logic [AW-1:0]   vrd_addr_c;
  logic [AW-1:0]   wr_addr_c;
  logic [DW-1:0]   wr_data_c;
  logic            last_gnt;
  logic            rd_pend;
  logic            unused_c;

  // Sub-tile pixel bits do not take part in addressing.
  assign unused_c = ^{pixel_x[4:0], pixel_y[4:0]};

  // Slot selection and round-robin winner for this cycle.
  always_comb begin
    slot_c      = SLOT_IDLE;
    win_c       = w_req[1];
`ifdef TILE_ARB_BLANK_WR_EN
    wr_window_c = ~video_on;
`else
    wr_window_c = 1'b1;
`endif
    vrd_addr_c  = AW'(pixel_y[9:5]) * AW'(MAP_W) + AW'(pixel_x[9:5]);
    if (w_req == 2'b11) begin
      win_c = ~last_gnt;
    end
    wr_addr_c = win_c ? w_addr1 : w_addr0;
    wr_data_c = win_c ? w_data1 : w_data0;
    wr_ok_c   = 32'(wr_addr_c) < TILE_CNT;
    if (pixel_tick && video_on) begin
      slot_c = SLOT_VRD;
    end else if ((w_req != 2'b00) && wr_window_c) begin
      slot_c = SLOT_WR;
    end
  end

  // Registered RAM command, grants, read return and error count.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      w_gnt      <= '0;
      tile_code  <= '0;
      tile_valid <= 1'b0;
      err_cnt    <= '0;
      last_gnt   <= 1'b1;
      rd_pend    <= 1'b0;
    end else begin
      w_gnt      <= '0;
      mem_we     <= 1'b0;
      rd_pend    <= 1'b0;
      tile_valid <= rd_pend;
      if (rd_pend) begin
        tile_code <= mem_rdata;
      end
      case (slot_c)
        SLOT_VRD: begin
          mem_addr <= vrd_addr_c;
          rd_pend  <= 1'b1;
        end
        SLOT_WR: begin
          w_gnt     <= win_c ? 2'b10 : 2'b01;
          last_gnt  <= win_c;
          mem_addr  <= wr_addr_c;
          mem_wdata <= wr_data_c;
          mem_we    <= wr_ok_c;
          // Out-of-range writes are granted but dropped and counted.
          if (!wr_ok_c && (err_cnt != {EW{1'b1}})) begin
            err_cnt <= err_cnt + EW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_mem_arbiter.sv
// Bench for tile_mem_arbiter: directed vector table, reset/saturation sequences,
// then randomized traffic against a rule-level reference model.
module tb_tile_mem_arbiter;

  localparam int MAP_W = 20;
  localparam int MAP_H = 15;
  localparam int NT    = MAP_W * MAP_H;

  logic       CLOCK_50 = 1'b0;
  logic       KEY;
  logic       pixel_tick, video_on;
  logic [9:0] pixel_x, pixel_y;
  logic [1:0] w_req;
  logic [8:0] w_addr0, w_addr1;
  logic [2:0] w_data0, w_data1;
  logic [1:0] w_gnt;
  logic [8:0] mem_addr;
  logic       mem_we;
  logic [2:0] mem_wdata, mem_rdata, tile_code;
  logic       tile_valid;
  logic [7:0] err_cnt;

  tile_mem_arbiter #(.MAP_W(MAP_W), .MAP_H(MAP_H)) dut (
    .CLOCK_50(CLOCK_50), .KEY(KEY), .pixel_tick(pixel_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .w_req(w_req),
    .w_addr0(w_addr0), .w_addr1(w_addr1), .w_data0(w_data0), .w_data1(w_data1),
    .w_gnt(w_gnt), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .tile_code(tile_code), .tile_valid(tile_valid), .err_cnt(err_cnt)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Tile RAM: registered write, read data presented for the current address.
  logic [2:0] ram [0:511];
  logic       ram_load;
  assign mem_rdata = ram[mem_addr];

  function automatic logic [2:0] init_val(int i);
    return 3'((i * 5 + 3) % 8);
  endfunction

  always @(posedge CLOCK_50) begin
    if (ram_load) begin
      for (int i = 0; i < 512; i++) ram[i] <= init_val(i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic tick; logic vo; int px; int py; logic [1:0] req;
    int a0; int d0; int a1; int d1;
    logic [1:0] gnt; logic we; int addr; int wd; logic tv; int tc; int err;
  } vec_t;

  vec_t tbl [15];

  task automatic drive(input logic tk, input logic vo, input int px, input int py,
                       input logic [1:0] rq, input int a0, input int d0, input int a1, input int d1);
    pixel_tick = tk; video_on = vo;
    pixel_x = 10'(px); pixel_y = 10'(py);
    w_req = rq;
    w_addr0 = 9'(a0); w_data0 = 3'(d0);
    w_addr1 = 9'(a1); w_data1 = 3'(d1);
  endtask

  // Reference model state
  int shadow [512];
  int rq [2], ra [2], rdat [2];
  int m_last, m_err;
  int c_gnt, c_we, c_addr, c_wd, c_tv, c_tc, c_read;
  int n_gnt, n_we, n_addr, n_wd, n_tv, n_tc, n_read;

  initial begin
    KEY = 1'b0; ram_load = 1'b1;
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    repeat (2) @(negedge CLOCK_50);
    chk("rst_addr", mem_addr, 0);   chk("rst_we", mem_we, 0);
    chk("rst_wdata", mem_wdata, 0); chk("rst_gnt", w_gnt, 0);
    chk("rst_tc", tile_code, 0);    chk("rst_tv", tile_valid, 0);
    chk("rst_err", err_cnt, 0);
    KEY = 1'b1; ram_load = 1'b0;

    //           tk vo  px   py  req   a0  d0 a1  d1 | gnt   we addr wd tv tc err
    tbl[0]  = '{1, 1, 100,  70, 2'b00,   5, 1,  6, 2, 2'b00, 0,  43, 0, 0, 0, 0};
    tbl[1]  = '{0, 0,   0,   0, 2'b11,   5, 1,  6, 2, 2'b01, 1,   5, 1, 1, 2, 0};
    tbl[2]  = '{0, 0,   0,   0, 2'b11,   5, 1,  6, 2, 2'b10, 1,   6, 2, 0, 2, 0};
    tbl[3]  = '{0, 0,   0,   0, 2'b11,   5, 1,  6, 2, 2'b01, 1,   5, 1, 0, 2, 0};
    tbl[4]  = '{0, 0,   0,   0, 2'b10,   5, 1,  6, 2, 2'b10, 1,   6, 2, 0, 2, 0};
    tbl[5]  = '{0, 0,   0,   0, 2'b10,   5, 1,  6, 2, 2'b10, 1,   6, 2, 0, 2, 0};
    tbl[6]  = '{0, 0,   0,   0, 2'b11,   5, 1,  6, 2, 2'b01, 1,   5, 1, 0, 2, 0};
    tbl[7]  = '{0, 0,   0,   0, 2'b00,   5, 1,  6, 2, 2'b00, 0,   5, 1, 0, 2, 0};
    tbl[8]  = '{1, 1, 639, 479, 2'b01,   5, 1,  6, 2, 2'b00, 0, 299, 1, 0, 2, 0};
    tbl[9]  = '{0, 0,   0,   0, 2'b01,   5, 1,  6, 2, 2'b01, 1,   5, 1, 1, 2, 0};
    tbl[10] = '{1, 0,   0,   0, 2'b00,   5, 1,  6, 2, 2'b00, 0,   5, 1, 0, 2, 0};
    tbl[11] = '{0, 0,   0,   0, 2'b01, 300, 7,  6, 2, 2'b01, 0, 300, 7, 0, 2, 1};
    tbl[12] = '{0, 0,   0,   0, 2'b10, 300, 7,299, 3, 2'b10, 1, 299, 3, 0, 2, 1};
    tbl[13] = '{1, 1,  31,  31, 2'b11, 300, 7,299, 3, 2'b00, 0,   0, 3, 0, 2, 1};
    tbl[14] = '{0, 0,   0,   0, 2'b11, 300, 7,299, 3, 2'b01, 0, 300, 7, 1, 3, 2};

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].tick, tbl[i].vo, tbl[i].px, tbl[i].py, tbl[i].req,
            tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1);
      @(negedge CLOCK_50);
      chk($sformatf("v%0d_gnt", i), w_gnt, tbl[i].gnt);
      chk($sformatf("v%0d_we", i), mem_we, tbl[i].we);
      chk($sformatf("v%0d_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("v%0d_wd", i), mem_wdata, tbl[i].wd);
      chk($sformatf("v%0d_tv", i), tile_valid, tbl[i].tv);
      chk($sformatf("v%0d_tc", i), tile_code, tbl[i].tc);
      chk($sformatf("v%0d_err", i), err_cnt, tbl[i].err);
    end
    chk("ram5", ram[5], 1);
    chk("ram6", ram[6], 2);
    chk("ram299", ram[299], 3);

    // Error counter saturation on repeated out-of-range writes
    drive(0, 0, 0, 0, 2'b01, 300, 5, 0, 0);
    for (int i = 0; i < 258; i++) begin
      @(negedge CLOCK_50);
      chk("sat_we", mem_we, 0);
      chk("sat_err", err_cnt, (2 + i + 1 > 255) ? 255 : 2 + i + 1);
    end

    // Reset asserted while a grant is on the bus
    drive(0, 0, 0, 0, 2'b01, 10, 0, 0, 0);
    @(posedge CLOCK_50); #1;
    chk("mid_gnt", w_gnt, 1);
    chk("mid_we", mem_we, 1);
    KEY = 1'b0; #1;
    chk("mid_rst_addr", mem_addr, 0); chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_wd", mem_wdata, 0);  chk("mid_rst_gnt", w_gnt, 0);
    chk("mid_rst_tc", tile_code, 0);  chk("mid_rst_tv", tile_valid, 0);
    chk("mid_rst_err", err_cnt, 0);
    @(negedge CLOCK_50);
    w_req = 2'b00;
    chk("mid_no_write", ram[10], 5);
    KEY = 1'b1;
    drive(0, 0, 0, 0, 2'b11, 20, 4, 21, 6);
    @(negedge CLOCK_50);
    chk("resume_gnt", w_gnt, 1);
    chk("resume_addr", mem_addr, 20);

`ifdef TILE_ARB_BLANK_WR_EN
    // Writes wait for blanking
    drive(0, 1, 0, 0, 2'b01, 30, 3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      chk("blank_wait_gnt", w_gnt, 0);
    end
    video_on = 1'b0;
    @(negedge CLOCK_50);
    chk("blank_gnt", w_gnt, 1);
`endif

    // Randomized traffic against the reference model
    KEY = 1'b0; ram_load = 1'b1;
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    @(negedge CLOCK_50);
    KEY = 1'b1; ram_load = 1'b0;
    for (int i = 0; i < 512; i++) shadow[i] = int'(init_val(i));
    for (int k = 0; k < 2; k++) begin rq[k] = 0; ra[k] = 0; rdat[k] = 0; end
    m_last = 1; m_err = 0;
    c_gnt = 0; c_we = 0; c_addr = 0; c_wd = 0; c_tv = 0; c_tc = 0; c_read = 0;

    for (int n = 0; n < 3000; n++) begin
      logic tk, vo;
      int px, py, req, k;
      for (int j = 0; j < 2; j++) begin
        if ((c_gnt >> j) & 1) rq[j] = 0;
        else if (rq[j] != 0 && $urandom_range(15, 0) == 0) rq[j] = 0;
        if (rq[j] == 0 && $urandom_range(3, 0) == 0) begin
          rq[j] = 1;
          ra[j] = $urandom_range(319, 0);
          rdat[j] = $urandom_range(7, 0);
        end
      end
      tk = 1'($urandom_range(1, 0));
      vo = ($urandom_range(3, 0) != 0);
      px = $urandom_range(639, 0);
      py = $urandom_range(479, 0);
      req = rq[0] + 2 * rq[1];
      drive(tk, vo, px, py, 2'(req), ra[0], rdat[0], ra[1], rdat[1]);

      n_tv = c_read;
      n_tc = c_read ? shadow[c_addr] : c_tc;
      if (c_we != 0) shadow[c_addr] = c_wd;
      n_gnt = 0; n_we = 0; n_addr = c_addr; n_wd = c_wd; n_read = 0;
      if (tk && vo) begin
        n_addr = (py / 32) * MAP_W + (px / 32);
        n_read = 1;
      end else if (req != 0
`ifdef TILE_ARB_BLANK_WR_EN
                   && !vo
`endif
                  ) begin
        if (req == 3) k = 1 - m_last;
        else k = (req == 2) ? 1 : 0;
        m_last = k;
        n_gnt = 1 << k;
        n_addr = ra[k];
        n_wd = rdat[k];
        if (ra[k] < NT) n_we = 1;
        else if (m_err < 255) m_err++;
      end

      @(negedge CLOCK_50);
      c_gnt = n_gnt; c_we = n_we; c_addr = n_addr; c_wd = n_wd;
      c_tv = n_tv; c_tc = n_tc; c_read = n_read;
      chk("rnd_gnt", w_gnt, c_gnt);
      chk("rnd_onehot", int'(w_gnt == 2'b11), 0);
      chk("rnd_we", mem_we, c_we);
      chk("rnd_addr", mem_addr, c_addr);
      chk("rnd_wd", mem_wdata, c_wd);
      chk("rnd_tv", tile_valid, c_tv);
      chk("rnd_tc", tile_code, c_tc);
      chk("rnd_err", err_cnt, m_err);
    end
    if (c_we != 0) shadow[c_addr] = c_wd;
    @(negedge CLOCK_50);
    for (int i = 0; i < NT; i++) chk($sformatf("ram_final%0d", i), ram[i], shadow[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
